// File: rtl/rps_move_gen_if.sv
// Button/move bus between the rock-paper-scissors round generator and its user.
// The master drives the raw buttons; the slave (rps_move_gen) drives the move outputs.
interface rps_move_gen_if;
    logic [2:0] btn_in;
    logic [2:0] user;
    logic [2:0] compu;
    logic       round_active;
    logic [3:0] round_cnt;

    modport master (
        output btn_in,
        input  user,
        input  compu,
        input  round_active,
        input  round_cnt
    );

    modport slave (
        input  btn_in,
        output user,
        output compu,
        output round_active,
        output round_cnt
    );
endinterface

// File: rtl/rps_move_gen.sv
// Rock-paper-scissors round generator: synchronises and debounces three buttons,
// draws a computer move from an LFSR and presents the move pair for a fixed time.
module rps_move_gen #(
    parameter int unsigned DEBOUNCE_CYC = 1000000,
    parameter int unsigned REVEAL_CYC   = 75000000
) (
    input logic           CLK,
    input logic           RST_N,
    rps_move_gen_if.slave bus
);
    localparam int unsigned   DW       = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam int unsigned   RW       = (REVEAL_CYC > 1) ? $clog2(REVEAL_CYC) : 1;
    localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_CYC - 1);
    localparam logic [RW-1:0] REV_LAST = RW'(REVEAL_CYC - 1);

    typedef enum logic [1:0] {IDLE, DRAW, SHOW, RELEASE} state_e;

    logic [2:0]    sync1_q, sync2_q, cand_q, clean_q, clean_prev_q;
    logic [DW-1:0] deb_cnt_q;
    logic [15:0]   lfsr_q;
    state_e        state_q, state_d;
    logic [2:0]    move_q, move_d;
    logic [2:0]    user_q, user_d;
    logic [2:0]    compu_q, compu_d;
    logic          act_q, act_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [RW-1:0] rev_q, rev_d;
    logic          press;
    logic [2:0]    draw_move;

    // Input synchroniser followed by a whole-vector debouncer.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            sync1_q      <= '0;
            sync2_q      <= '0;
            cand_q       <= '0;
            clean_q      <= '0;
            clean_prev_q <= '0;
            deb_cnt_q    <= '0;
        end else begin
            sync1_q      <= bus.btn_in;
            sync2_q      <= sync1_q;
            clean_prev_q <= clean_q;
            if (sync2_q != cand_q) begin
                cand_q    <= sync2_q;
                deb_cnt_q <= '0;
            end else if (deb_cnt_q == DEB_LAST) begin
                clean_q <= cand_q;
            end else begin
                deb_cnt_q <= deb_cnt_q + DW'(1);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) lfsr_q <= 16'hACE1;
        else        lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end

    assign press = (clean_prev_q == 3'b000) && $onehot(clean_q);

    always_comb begin
        case (lfsr_q[1:0])
            2'b00:   draw_move = 3'b001;
            2'b01:   draw_move = 3'b010;
            2'b10:   draw_move = 3'b100;
            default: draw_move = 3'b000;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q <= IDLE;
            move_q  <= '0;
            user_q  <= '0;
            compu_q <= '0;
            act_q   <= 1'b0;
            cnt_q   <= '0;
            rev_q   <= '0;
        end else begin
            state_q <= state_d;
            move_q  <= move_d;
            user_q  <= user_d;
            compu_q <= compu_d;
            act_q   <= act_d;
            cnt_q   <= cnt_d;
            rev_q   <= rev_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (press) state_d = DRAW;
            DRAW:    if (lfsr_q[1:0] != 2'b11) state_d = SHOW;
            SHOW:    if (rev_q == REV_LAST) state_d = RELEASE;
            RELEASE: if (clean_q == 3'b000) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Both moves are loaded on the same edge so the pair is never seen half-valid.
    always_comb begin
        move_d  = move_q;
        user_d  = '0;
        compu_d = '0;
        act_d   = 1'b0;
        cnt_d   = cnt_q;
        rev_d   = '0;
        case (state_q)
            IDLE: begin
                if (press) move_d = clean_q;
            end
            DRAW: begin
                if (state_d == SHOW) begin
                    user_d  = move_q;
                    compu_d = draw_move;
                    act_d   = 1'b1;
                    cnt_d   = (cnt_q == 4'd15) ? cnt_q : cnt_q + 4'd1;
                end
            end
            SHOW: begin
                if (state_d == SHOW) begin
                    user_d  = user_q;
                    compu_d = compu_q;
                    act_d   = act_q;
                    rev_d   = rev_q + RW'(1);
                end
            end
            default: ;
        endcase
    end

    assign bus.user         = user_q;
    assign bus.compu        = compu_q;
    assign bus.round_active = act_q;
    assign bus.round_cnt    = cnt_q;
endmodule

// File: tb/tb_rps_move_gen.sv
// Directed bench for rps_move_gen with DEBOUNCE_CYC=4, REVEAL_CYC=8; the computer
// move and round latency are predicted from an independent LFSR model.
module tb_rps_move_gen;
    logic CLK = 1'b0;
    logic RST_N = 1'b0;
    rps_move_gen_if bus();

    rps_move_gen #(.DEBOUNCE_CYC(4), .REVEAL_CYC(8)) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_bad = 0;
    int exp_cnt = 0;
    logic [15:0] m_lfsr;

    function automatic logic [15:0] lstep(input logic [15:0] v);
        return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    endfunction

    function automatic logic [2:0] cmap(input logic [1:0] s);
        case (s)
            2'b00:   return 3'b001;
            2'b01:   return 3'b010;
            2'b10:   return 3'b100;
            default: return 3'b000;
        endcase
    endfunction

    always @(posedge CLK) m_lfsr <= !RST_N ? 16'hACE1 : lstep(m_lfsr);

    // Called at a negedge right after the button (or reset release) is applied.
    // Edge k=0 is the next posedge; the first draw decision is made at edge 8.
    task automatic watch_round(output int got, output int expd, output logic [2:0] ec);
        got = -1; expd = -1; ec = '0;
        for (int k = 0; k < 60; k++) begin
            if (k >= 8 && expd < 0 && m_lfsr[1:0] != 2'b11) begin
                expd = k;
                ec = cmap(m_lfsr[1:0]);
            end
            @(posedge CLK); @(negedge CLK);
            if (got < 0 && bus.round_active === 1'b1) got = k;
            if (got >= 0 && expd >= 0) break;
        end
    endtask

    task automatic measure_high(output int n, output bit stable);
        logic [2:0] u0, c0;
        u0 = bus.user; c0 = bus.compu;
        n = 0; stable = 1'b1;
        for (int k = 0; k < 40 && bus.round_active === 1'b1; k++) begin
            n++;
            if (bus.user !== u0 || bus.compu !== c0) stable = 1'b0;
            @(posedge CLK); @(negedge CLK);
        end
    endtask

    task automatic idle_cycles(input int n, output int highs);
        highs = 0;
        for (int k = 0; k < n; k++) begin
            @(negedge CLK);
            if (bus.round_active !== 1'b0) highs++;
        end
    endtask

    task automatic test_reset;
        int h;
        bus.btn_in = 3'b000;
        RST_N = 1'b0;
        repeat (3) @(negedge CLK);
        n_cmp++; if (bus.user !== 3'b000) begin n_bad++; $display("FAIL reset_user: got %b want 000", bus.user); end
        n_cmp++; if (bus.compu !== 3'b000) begin n_bad++; $display("FAIL reset_compu: got %b want 000", bus.compu); end
        n_cmp++; if (bus.round_active !== 1'b0) begin n_bad++; $display("FAIL reset_active: got %b want 0", bus.round_active); end
        n_cmp++; if (bus.round_cnt !== 4'd0) begin n_bad++; $display("FAIL reset_cnt: got %0d want 0", bus.round_cnt); end
        RST_N = 1'b1;
        idle_cycles(15, h);
        n_cmp++; if (h !== 0) begin n_bad++; $display("FAIL reset_quiet: got %0d active cycles want 0", h); end
    endtask

    task automatic test_basic;
        int got, expd, n, h; bit st; logic [2:0] ec;
        bus.btn_in = 3'b010;
        watch_round(got, expd, ec);
        exp_cnt++;
        n_cmp++; if (got !== expd) begin n_bad++; $display("FAIL basic_latency: got edge %0d want %0d", got, expd); end
        n_cmp++; if (bus.user !== 3'b010) begin n_bad++; $display("FAIL basic_user: got %b want 010", bus.user); end
        n_cmp++; if (bus.compu !== ec) begin n_bad++; $display("FAIL basic_compu: got %b want %b", bus.compu, ec); end
        n_cmp++; if (bus.round_cnt !== 4'(exp_cnt)) begin n_bad++; $display("FAIL basic_cnt: got %0d want %0d", bus.round_cnt, exp_cnt); end
        measure_high(n, st);
        n_cmp++; if (n !== 8) begin n_bad++; $display("FAIL basic_show_len: got %0d want 8", n); end
        n_cmp++; if (st !== 1'b1) begin n_bad++; $display("FAIL basic_show_stable: got %b want 1", st); end
        n_cmp++; if (bus.user !== 3'b000 || bus.compu !== 3'b000) begin n_bad++; $display("FAIL basic_release_clear: got %b/%b want 000/000", bus.user, bus.compu); end
        bus.btn_in = 3'b000;
        idle_cycles(20, h);
    endtask

    task automatic test_bounce;
        int h, h2;
        h = 0;
        for (int i = 0; i < 10; i++) begin
            bus.btn_in = (i % 2 == 0) ? 3'b001 : 3'b000;
            idle_cycles(2, h2);
            h += h2;
        end
        bus.btn_in = 3'b000;
        idle_cycles(20, h2);
        h += h2;
        n_cmp++; if (h !== 0) begin n_bad++; $display("FAIL bounce_no_round: got %0d active cycles want 0", h); end
        n_cmp++; if (bus.round_cnt !== 4'(exp_cnt)) begin n_bad++; $display("FAIL bounce_cnt: got %0d want %0d", bus.round_cnt, exp_cnt); end
    endtask

    task automatic test_multibit;
        int got, expd, n, h, h2; bit st; logic [2:0] ec;
        bus.btn_in = 3'b011;
        idle_cycles(20, h);
        bus.btn_in = 3'b000;
        idle_cycles(20, h2);
        n_cmp++; if (h + h2 !== 0) begin n_bad++; $display("FAIL multibit_no_round: got %0d active cycles want 0", h + h2); end
        bus.btn_in = 3'b100;
        watch_round(got, expd, ec);
        exp_cnt++;
        n_cmp++; if (got !== expd) begin n_bad++; $display("FAIL multibit_latency: got edge %0d want %0d", got, expd); end
        n_cmp++; if (bus.user !== 3'b100) begin n_bad++; $display("FAIL multibit_user: got %b want 100", bus.user); end
        n_cmp++; if (bus.compu !== ec) begin n_bad++; $display("FAIL multibit_compu: got %b want %b", bus.compu, ec); end
        n_cmp++; if (bus.round_cnt !== 4'(exp_cnt)) begin n_bad++; $display("FAIL multibit_cnt: got %0d want %0d", bus.round_cnt, exp_cnt); end
        measure_high(n, st);
        n_cmp++; if (n !== 8) begin n_bad++; $display("FAIL multibit_show_len: got %0d want 8", n); end
        bus.btn_in = 3'b000;
        idle_cycles(20, h);
    endtask

    task automatic test_hold;
        int got, expd, n, h; bit st; logic [2:0] ec;
        bus.btn_in = 3'b001;
        watch_round(got, expd, ec);
        exp_cnt++;
        n_cmp++; if (got !== expd) begin n_bad++; $display("FAIL hold_latency: got edge %0d want %0d", got, expd); end
        n_cmp++; if (bus.user !== 3'b001 || bus.compu !== ec) begin n_bad++; $display("FAIL hold_moves: got %b/%b want 001/%b", bus.user, bus.compu, ec); end
        measure_high(n, st);
        n_cmp++; if (n !== 8) begin n_bad++; $display("FAIL hold_show_len: got %0d want 8", n); end
        idle_cycles(50, h);
        n_cmp++; if (h !== 0) begin n_bad++; $display("FAIL hold_single_round: got %0d active cycles want 0", h); end
        n_cmp++; if (bus.round_cnt !== 4'(exp_cnt)) begin n_bad++; $display("FAIL hold_cnt: got %0d want %0d", bus.round_cnt, exp_cnt); end
        bus.btn_in = 3'b000;
        idle_cycles(20, h);
        n_cmp++; if (h !== 0) begin n_bad++; $display("FAIL hold_release_quiet: got %0d active cycles want 0", h); end
    endtask

    task automatic test_reject;
        int got, expd, n, d, h; bit st; logic [2:0] ec; logic [15:0] v;
        v = m_lfsr;
        for (int i = 0; i < 8; i++) v = lstep(v);
        d = 0;
        while (v[1:0] != 2'b11 && d < 64) begin v = lstep(v); d++; end
        repeat (d) @(negedge CLK);
        bus.btn_in = 3'b100;
        watch_round(got, expd, ec);
        exp_cnt++;
        n_cmp++; if (got !== expd) begin n_bad++; $display("FAIL reject_latency: got edge %0d want %0d", got, expd); end
        n_cmp++; if (got <= 8) begin n_bad++; $display("FAIL reject_delayed: got edge %0d want > 8", got); end
        n_cmp++; if (bus.compu !== ec) begin n_bad++; $display("FAIL reject_compu: got %b want %b", bus.compu, ec); end
        n_cmp++; if (bus.user !== 3'b100) begin n_bad++; $display("FAIL reject_user: got %b want 100", bus.user); end
        measure_high(n, st);
        n_cmp++; if (n !== 8) begin n_bad++; $display("FAIL reject_show_len: got %0d want 8", n); end
        bus.btn_in = 3'b000;
        idle_cycles(20, h);
    endtask

    task automatic test_saturate;
        int got, expd, n, h; bit st; logic [2:0] ec;
        logic [2:0] pats [3];
        pats = '{3'b001, 3'b010, 3'b100};
        while (exp_cnt < 16) begin
            bus.btn_in = pats[exp_cnt % 3];
            watch_round(got, expd, ec);
            exp_cnt++;
            n_cmp++; if (got !== expd || bus.user !== pats[(exp_cnt - 1) % 3] || bus.compu !== ec) begin
                n_bad++;
                $display("FAIL sat_round%0d: got edge %0d %b/%b want edge %0d %b/%b", exp_cnt, got, bus.user, bus.compu, expd, pats[(exp_cnt - 1) % 3], ec);
            end
            n_cmp++; if (bus.round_cnt !== 4'((exp_cnt > 15) ? 15 : exp_cnt)) begin n_bad++; $display("FAIL sat_cnt%0d: got %0d want %0d", exp_cnt, bus.round_cnt, (exp_cnt > 15) ? 15 : exp_cnt); end
            measure_high(n, st);
            bus.btn_in = 3'b000;
            idle_cycles(20, h);
        end
        n_cmp++; if (bus.round_cnt !== 4'd15) begin n_bad++; $display("FAIL sat_final: got %0d want 15", bus.round_cnt); end
    endtask

    task automatic test_reset_mid_show;
        int got, expd, n, h; bit st; logic [2:0] ec;
        bus.btn_in = 3'b010;
        watch_round(got, expd, ec);
        n_cmp++; if (got !== expd) begin n_bad++; $display("FAIL r17_latency: got edge %0d want %0d", got, expd); end
        n_cmp++; if (bus.round_cnt !== 4'd15) begin n_bad++; $display("FAIL r17_cnt_held: got %0d want 15", bus.round_cnt); end
        repeat (3) @(negedge CLK);
        RST_N = 1'b0;
        @(posedge CLK); #1;
        n_cmp++; if (bus.user !== 3'b000 || bus.compu !== 3'b000) begin n_bad++; $display("FAIL rst_show_moves: got %b/%b want 000/000", bus.user, bus.compu); end
        n_cmp++; if (bus.round_active !== 1'b0) begin n_bad++; $display("FAIL rst_show_active: got %b want 0", bus.round_active); end
        n_cmp++; if (bus.round_cnt !== 4'd0) begin n_bad++; $display("FAIL rst_show_cnt: got %0d want 0", bus.round_cnt); end
        repeat (2) @(negedge CLK);
        RST_N = 1'b1;
        watch_round(got, expd, ec);
        n_cmp++; if (got !== expd) begin n_bad++; $display("FAIL held_after_rst_latency: got edge %0d want %0d", got, expd); end
        n_cmp++; if (bus.user !== 3'b010 || bus.compu !== ec) begin n_bad++; $display("FAIL held_after_rst_moves: got %b/%b want 010/%b", bus.user, bus.compu, ec); end
        n_cmp++; if (bus.round_cnt !== 4'd1) begin n_bad++; $display("FAIL held_after_rst_cnt: got %0d want 1", bus.round_cnt); end
        measure_high(n, st);
        n_cmp++; if (n !== 8) begin n_bad++; $display("FAIL held_after_rst_show_len: got %0d want 8", n); end
        bus.btn_in = 3'b000;
        idle_cycles(20, h);
    endtask

    initial begin
        bus.btn_in = 3'b000;
        @(negedge CLK);
        test_reset;
        test_basic;
        test_bounce;
        test_multibit;
        test_hold;
        test_reject;
        test_saturate;
        test_reset_mid_show;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no completion want finish before time limit");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/rps_move_gen.md
RPS_MOVE_GEN -- requirements
Module: rps_move_gen

Interface
REQ-001 Parameter DEBOUNCE_CYC, default 1000000; consecutive stable sampled cycles required to accept a button change (20 ms at 50 MHz).
REQ-002 Parameter REVEAL_CYC, default 75000000; cycles a round's moves are presented (1.5 s at 50 MHz).
REQ-003 CLK  input  1  system clock; all logic rising-edge of CLK, single clock domain.
REQ-004 RST_N  input  1  reset, synchronous, active-low.
REQ-005 btn_in  input  3  raw user buttons, active-high, asynchronous, bouncing; bit0 rock, bit1 scissors, bit2 paper.
REQ-006 user  output  3  registered one-hot user move (001 rock, 010 scissors, 100 paper); 000 = no move.
REQ-007 compu  output  3  registered one-hot computer move, same encoding; 000 = no move.
REQ-008 round_active  output  1  high exactly while user and compu carry a valid move pair.
REQ-009 round_cnt  output  4  number of rounds presented since reset, saturating.

Function
REQ-010 btn_in SHALL pass through a 2-flop synchronizer per bit before any other use.
REQ-011 Debounce SHALL operate on the 3-bit synchronized vector: on mismatch with candidate, candidate takes the new value and counter clears; on match, counter increments; when counter reaches DEBOUNCE_CYC-1, clean vector takes candidate.
REQ-012 A valid press SHALL be a cycle where clean changes from 000 to a value with exactly one bit set; multi-bit values are ignored and do not constitute a press.
REQ-013 A 16-bit Fibonacci LFSR, taps 16,14,13,11, SHALL advance every cycle regardless of state.
REQ-014 FSM states SHALL be IDLE, DRAW, SHOW, RELEASE.
REQ-015 IDLE: user=000, compu=000, round_active=0; on valid press, latch clean into an internal move register and go to DRAW.
REQ-016 DRAW: outputs held at 000; if lfsr[1:0]==11, stay (reject); otherwise capture compu move (00->001, 01->010, 10->100), go to SHOW.
REQ-017 On DRAW->SHOW edge, user and compu SHALL update in the same cycle; round_active rises in that cycle; downstream never sees only one of them non-zero.
REQ-018 On DRAW->SHOW edge, round_cnt SHALL increment, holding at 15 once reached.
REQ-019 SHOW: outputs held for exactly REVEAL_CYC cycles, then go to RELEASE.
REQ-020 RELEASE: user, compu, round_active return to 0 on entry; remain until clean==000, then go to IDLE.
REQ-021 Button activity during DRAW, SHOW or RELEASE SHALL NOT start or alter a round; one press yields at most one round.
REQ-022 Latency: valid press to round_active high SHALL be 2 cycles plus one cycle per LFSR rejection.

Reset
REQ-023 With RST_N low at a CLK edge: state IDLE, user=000, compu=000, round_active=0, round_cnt=0, LFSR=16'hACE1, synchronizer, candidate and clean vectors=000, counters=0.
REQ-024 Reset asserted in any state, including mid-SHOW, SHALL clear outputs on that edge; no round resumes after release of reset.
REQ-025 After reset release, a button already held SHALL produce a round only once debounced (clean 000 -> one-hot transition).

Verification (DEBOUNCE_CYC=4, REVEAL_CYC=8)
REQ-026 Reset, btn_in=010 held clean -> after sync+debounce user=010, compu one-hot, round_active high exactly 8 cycles, round_cnt=1.
REQ-027 btn_in=001 toggling every 2 cycles for 20 cycles then 000 -> no round, round_cnt unchanged.
REQ-028 btn_in=011 held 20 cycles -> no round; release then press 100 -> one round with user=100.
REQ-029 Hold btn_in=001 through SHOW and 50 further cycles -> single round, FSM stays RELEASE until release, then IDLE.
REQ-030 Force LFSR state with lfsr[1:0]==11 at DRAW entry -> DRAW persists until lfsr[1:0]!=11; compu matches mapping of the accepted value.
REQ-031 16 completed rounds -> round_cnt=15; RST_N low during round 17 SHOW -> all outputs 0 at next edge, round_cnt=0.
